// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave controller: synchronizes the SPI pins, sequences bit/word
// framing and moves words between the shift registers and the core side.
module spi_slave_ctrl #(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_err,
   output logic              underrun,
   output logic [1:0]        state_dbg
);

   // Core-side transmit handshake: a word moves into the holding register on
   // any clk edge where tx_valid & tx_ready; tx_ready is simply "holding register empty".

   localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t            state;
   logic              sclk_m, sclk_s, sclk_d;
   logic              cs_m, cs_s, cs_d;
   logic              mosi_m, mosi_s;
   logic [CW-1:0]     cnt;
   logic              word_done;
   logic [DATA_W-1:0] shift_rx;
   logic [DATA_W-1:0] shift_tx;
   logic [DATA_W-1:0] hold;
   logic              hold_full;

   logic rise, fall, cs_start, cs_end;

   assign rise      = sclk_s & ~sclk_d;
   assign fall      = ~sclk_s & sclk_d;
   assign cs_start  = ~cs_s & cs_d;
   assign cs_end    = cs_s & ~cs_d;
   assign tx_ready  = ~hold_full;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_m    <= 1'b0;
         sclk_s    <= 1'b0;
         sclk_d    <= 1'b0;
         cs_m      <= 1'b1;
         cs_s      <= 1'b1;
         cs_d      <= 1'b1;
         mosi_m    <= 1'b0;
         mosi_s    <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         word_done <= 1'b0;
         shift_rx  <= '0;
         shift_tx  <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         miso      <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         sclk_m    <= sclk;
         sclk_s    <= sclk_m;
         sclk_d    <= sclk_s;
         cs_m      <= cs_n;
         cs_s      <= cs_m;
         cs_d      <= cs_s;
         mosi_m    <= mosi;
         mosi_s    <= mosi_m;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;

         // Chip-select release wins over everything, including a coincident rise.
         if (cs_end) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso      <= 1'b0;
            cnt       <= '0;
            word_done <= 1'b0;
            frame_err <= (cnt != '0);
         end else begin
            case (state)
               IDLE: begin
                  cnt  <= '0;
                  miso <= 1'b0;
                  if (cs_start) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (hold_full) begin
                     shift_tx <= hold;
                     miso     <= hold[DATA_W-1];
                  end else begin
                     shift_tx <= FILL;
                     miso     <= FILL[DATA_W-1];
                     underrun <= 1'b1;
                  end
                  hold_full <= 1'b0;
                  state     <= SHIFT;
               end
               SHIFT: begin
                  if (rise) begin
                     shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
                     if (cnt == LAST) begin
                        rx_data   <= {shift_rx[DATA_W-2:0], mosi_s};
                        rx_valid  <= 1'b1;
                        cnt       <= '0;
                        word_done <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else if (fall) begin
                     // The fall closing a word fetches the next word instead of shifting.
                     if (word_done) begin
                        word_done <= 1'b0;
                        state     <= LOAD;
                     end else if (cnt != '0) begin
                        shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
                        miso     <= shift_tx[DATA_W-2];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // Placed after LOAD so a same-cycle write refills the register for the next word.
         if (tx_valid && tx_ready) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule
